// File: rtl/main_fsm.sv
// main_fsm: multicycle RV32I control FSM driving datapath enables and mux selects.
module main_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regWrite,
   output logic [1:0] resultSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic [3:0] state,
   output logic       illegalOp
);
   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
      EXECUTER = 4'd6, ALUWB = 4'd7, EXECUTEI = 4'd8, JAL = 4'd9, BEQ = 4'd10
   } state_t;

   state_t state_q, state_d;
   logic   pc_update, branch, ir_en, rw_en, mw_en, ill;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;

   always_comb begin
      state_d   = FETCH;
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_en     = 1'b0;
      rw_en     = 1'b0;
      mw_en     = 1'b0;
      ill       = 1'b0;
      adrSrc    = 1'b0;
      resultSrc = 2'b00;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b00;
      aluOp     = 2'b00;
      case (state_q)
         FETCH: begin
            state_d   = memReady ? DECODE : FETCH;
            aluSrcB   = 2'b10;
            resultSrc = 2'b10;
            ir_en     = memReady;
            pc_update = memReady;
         end
         DECODE: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECUTER;
               OP_I:         state_d = EXECUTEI;
               OP_JAL:       state_d = JAL;
               OP_BEQ:       state_d = BEQ;
               default:      ill     = 1'b1;
            endcase
         end
         MEMADR: begin
            state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
         end
         MEMREAD: begin
            state_d = memReady ? MEMWB : MEMREAD;
            adrSrc  = 1'b1;
         end
         MEMWB: begin
            resultSrc = 2'b01;
            rw_en     = 1'b1;
         end
         MEMWRITE: begin
            state_d = memReady ? FETCH : MEMWRITE;
            adrSrc  = 1'b1;
            mw_en   = 1'b1;
         end
         EXECUTER: begin
            state_d = ALUWB;
            aluSrcA = 2'b10;
            aluOp   = 2'b10;
         end
         EXECUTEI: begin
            state_d = ALUWB;
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
            aluOp   = 2'b10;
         end
         ALUWB: rw_en = 1'b1;
         JAL: begin
            state_d   = ALUWB;
            aluSrcA   = 2'b01;
            aluSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         BEQ: begin
            aluSrcA = 2'b10;
            aluOp   = 2'b01;
            branch  = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Enables are gated by rst_n so they drop the instant reset asserts.
   assign pcWrite   = rst_n & (pc_update | (branch & zero));
   assign irWrite   = rst_n & ir_en;
   assign regWrite  = rst_n & rw_en;
   assign memWrite  = rst_n & mw_en;
   assign illegalOp = rst_n & ill;
   assign state     = state_q;
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed and random instruction sequences checked against a per-instruction state-path model.
module tb_main_fsm;
   logic       clk = 1'b0, rst_n = 1'b0, zero = 1'b0, memReady = 1'b0;
   logic [6:0] op = 7'd0;
   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegalOp;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
   logic [3:0] state;
   logic [13:0] ctrl;
   int n_checks = 0, n_fail = 0;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

   always #5 clk = ~clk;

   main_fsm dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
      .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .aluOp(aluOp), .state(state), .illegalOp(illegalOp)
   );

   assign ctrl = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB, aluOp, illegalOp};

   function automatic bit legal(logic [6:0] o);
      return o inside {LW, SW, RT, IT, JL, BQ};
   endfunction

   // Control word each state must present, straight from the output table.
   function automatic logic [13:0] model(int s, bit rdy, bit z, logic [6:0] o);
      logic pcw, adr, mw, ir, rw, ill;
      logic [1:0] res, a, b, aop;
      {pcw, adr, mw, ir, rw, ill} = '0;
      {res, a, b, aop} = '0;
      case (s)
         0:  begin b = 2'd2; res = 2'd2; ir = rdy; pcw = rdy; end
         1:  begin a = 2'd1; b = 2'd1; ill = !legal(o); end
         2:  begin a = 2'd2; b = 2'd1; end
         3:  adr = 1'b1;
         4:  begin res = 2'd1; rw = 1'b1; end
         5:  begin adr = 1'b1; mw = 1'b1; end
         6:  begin a = 2'd2; aop = 2'd2; end
         7:  rw = 1'b1;
         8:  begin a = 2'd2; b = 2'd1; aop = 2'd2; end
         9:  begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
         10: begin a = 2'd2; aop = 2'd1; pcw = z; end
         default: ;
      endcase
      return {pcw, adr, mw, ir, rw, res, a, b, aop, ill};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Builds the expected state path of one instruction, then drives and checks it cycle by cycle.
   task automatic run_instr(logic [6:0] o, int fs, int ms, bit z);
      int sq[$];
      bit rq[$];
      for (int i = 0; i < fs; i++) begin sq.push_back(0); rq.push_back(1'b0); end
      sq.push_back(0); rq.push_back(1'b1);
      sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
      if (o == LW || o == SW) begin
         sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
         for (int i = 0; i < ms; i++) begin sq.push_back(o == LW ? 3 : 5); rq.push_back(1'b0); end
         sq.push_back(o == LW ? 3 : 5); rq.push_back(1'b1);
         if (o == LW) begin sq.push_back(4); rq.push_back(1'($urandom_range(0, 1))); end
      end else if (o == RT || o == IT || o == JL) begin
         sq.push_back(o == RT ? 6 : o == IT ? 8 : 9); rq.push_back(1'($urandom_range(0, 1)));
         sq.push_back(7); rq.push_back(1'($urandom_range(0, 1)));
      end else if (o == BQ) begin
         sq.push_back(10); rq.push_back(1'($urandom_range(0, 1)));
      end
      foreach (sq[i]) begin
         op = o;
         zero = z;
         memReady = rq[i];
         #1;
         check($sformatf("state op=%b step=%0d", o, i), 32'(state), 32'(sq[i]));
         check($sformatf("ctrl op=%b step=%0d st=%0d", o, i, sq[i]), 32'(ctrl), 32'(model(sq[i], rq[i], z, o)));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [6:0] ops[6] = '{LW, SW, RT, IT, JL, BQ};
      logic [6:0] o;
      int k;
      rst_n = 1'b0;
      memReady = 1'b1;
      op = LW;
      zero = 1'b1;
      #12;
      check("rst_state", 32'(state), 32'd0);
      check("rst_pcWrite", 32'(pcWrite), 32'd0);
      check("rst_irWrite", 32'(irWrite), 32'd0);
      check("rst_regWrite", 32'(regWrite), 32'd0);
      check("rst_memWrite", 32'(memWrite), 32'd0);
      check("rst_illegalOp", 32'(illegalOp), 32'd0);
      check("rst_aluSrcB", 32'(aluSrcB), 32'd2);
      check("rst_resultSrc", 32'(resultSrc), 32'd2);
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(LW, 0, 0, 1'b0);
      run_instr(RT, 0, 0, 1'b0);
      run_instr(BQ, 0, 0, 1'b1);
      run_instr(BQ, 0, 0, 1'b0);
      run_instr(SW, 3, 2, 1'b0);
      run_instr(JL, 0, 0, 1'b1);
      run_instr(7'h7f, 0, 0, 1'b0);
      run_instr(IT, 1, 0, 1'b1);
      run_instr(LW, 2, 3, 1'b1);
      repeat (40) begin
         k = $urandom_range(0, 7);
         o = (k < 6) ? ops[k] : 7'($urandom);
         run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      // Asynchronous reset while a store is waiting on memory.
      op = SW;
      zero = 1'b0;
      memReady = 1'b1;
      for (int c = 0; c < 20 && state != 4'd5; c++) begin
         @(posedge clk);
         #1;
      end
      memReady = 1'b0;
      #1;
      check("mid_reach_memwrite", 32'(state), 32'd5);
      check("mid_memWrite_before", 32'(memWrite), 32'd1);
      memReady = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_state", 32'(state), 32'd0);
      check("mid_memWrite", 32'(memWrite), 32'd0);
      check("mid_irWrite", 32'(irWrite), 32'd0);
      check("mid_pcWrite", 32'(pcWrite), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
